// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg                                                            |
// | Shared state encoding and default chain length for shift_sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shift_pkg;

  localparam int c_default_width = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_chain                                                          |
// | WIDTH-bit shift register: parallel load, shift-enable, sync clear.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_chain
  import shift_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_shift_in;
    logic r_bit;

    if (i == 0) begin : g_lsb
      assign w_shift_in = SI;
    end else begin : g_upper
      assign w_shift_in = Q[i-1];
    end

    // Load takes priority over shift so a new word is never corrupted.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_bit <= 1'b0;
      end else if (LD) begin
        r_bit <= D[i];
      end else if (EN) begin
        r_bit <= w_shift_in;
      end
    end

    assign Q[i] = r_bit;
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_sequencer                                                      |
// | Full-duplex serial transfer controller: MSB-first out, capture in.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DIN,
  input  logic             HOLD,
  input  logic             SI,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_count;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  w_chain;
  logic              w_load;
  logic              w_shift;
  logic              w_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_last       = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_load       = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        BUSY = 1'b1;
        if (!HOLD) begin
          w_shift = 1'b1;
          if (r_count == c_last) begin
            w_last       = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        BUSY         = 1'b1;
        DONE         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counter parks at its final value rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST || w_load) begin
      r_count <= '0;
    end else if (w_shift && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else if (w_last) begin
      r_q <= {w_chain[WIDTH-2:0], SI};
    end
  end

  shift_chain #(
    .WIDTH (WIDTH)
  ) u_chain (
    .CLK (CLK),
    .RST (RST),
    .LD  (w_load),
    .EN  (w_shift),
    .D   (DIN),
    .SI  (SI),
    .Q   (w_chain)
  );

  assign SO = w_chain[WIDTH-1];
  assign Q  = r_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_sequencer                                                   |
// | Scoreboard bench for shift_sequencer at WIDTH 6, 2 and 16.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_shift_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, hold, si;
  logic [5:0]  din;
  logic        so, busy, done;
  logic [5:0]  q;

  logic        start2, si2;
  logic [1:0]  din2;
  logic        so2, busy2, done2;
  logic [1:0]  q2;

  logic        start16, si16;
  logic [15:0] din16;
  logic        so16, busy16, done16;
  logic [15:0] q16;

  logic        hold_off;

  shift_sequencer #(.WIDTH(6)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .DIN(din), .HOLD(hold), .SI(si),
    .SO(so), .BUSY(busy), .DONE(done), .Q(q)
  );

  shift_sequencer #(.WIDTH(2)) u_dut_w2 (
    .CLK(clk), .RST(rst), .START(start2), .DIN(din2), .HOLD(hold_off), .SI(si2),
    .SO(so2), .BUSY(busy2), .DONE(done2), .Q(q2)
  );

  shift_sequencer #(.WIDTH(16)) u_dut_w16 (
    .CLK(clk), .RST(rst), .START(start16), .DIN(din16), .HOLD(hold_off), .SI(si16),
    .SO(so16), .BUSY(busy16), .DONE(done16), .Q(q16)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [5:0]  q6_exp[$];
  logic [1:0]  q2_exp[$];
  logic [15:0] q16_exp[$];
  int          done_times[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitors: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_times.push_back(cyc);
      if (q6_exp.size() == 0) chk("w6_unexpected_done", 1, 0);
      else chk("w6_q", q, q6_exp.pop_front());
    end
    if (done2 === 1'b1) begin
      if (q2_exp.size() == 0) chk("w2_unexpected_done", 1, 0);
      else chk("w2_q", q2, q2_exp.pop_front());
    end
    if (done16 === 1'b1) begin
      if (q16_exp.size() == 0) chk("w16_unexpected_done", 1, 0);
      else chk("w16_q", q16, q16_exp.pop_front());
    end
  end

  task automatic xfer6(input logic [5:0] d, input logic [5:0] s,
                       input int hold_at, input int hold_len, input bit poke);
    start = 1'b1;
    din   = d;
    @(posedge clk);
    #1;
    q6_exp.push_back(s);
    if (poke) begin
      start = 1'b1;
      din   = 6'h3F;
    end else begin
      start = 1'b0;
      din   = ~d;
    end
    @(negedge clk);
    chk("w6_so_load", so, d[5]);
    chk("w6_busy_shift", busy, 1);
    for (int j = 1; j <= 6; j++) begin
      if (j == hold_at + 1) begin
        for (int h = 0; h < hold_len; h++) begin
          hold = 1'b1;
          si   = ~s[6-j];
          @(posedge clk);
          @(negedge clk);
          chk("w6_so_held", so, d[6-j]);
          chk("w6_done_held", done, 0);
        end
      end
      hold = 1'b0;
      si   = s[6-j];
      @(posedge clk);
      @(negedge clk);
      if (j < 6) chk("w6_so_shift", so, d[5-j]);
    end
    chk("w6_done_pulse", done, 1);
    hold = poke;
    @(posedge clk);
    #1;
    start = 1'b0;
    hold  = 1'b0;
    @(negedge clk);
    chk("w6_busy_end", busy, 0);
    chk("w6_done_end", done, 0);
  endtask

  task automatic xfer_w(input int w, input logic [15:0] d, input logic [15:0] s);
    if (w == 2) begin
      start2 = 1'b1;
      din2   = d[1:0];
      q2_exp.push_back(s[1:0]);
    end else begin
      start16 = 1'b1;
      din16   = d;
      q16_exp.push_back(s);
    end
    @(posedge clk);
    #1;
    start2  = 1'b0;
    start16 = 1'b0;
    for (int j = 1; j <= w; j++) begin
      @(negedge clk);
      chk((w == 2) ? "w2_so" : "w16_so", (w == 2) ? so2 : so16, d[w-j]);
      if (w == 2) si2 = s[w-j];
      else si16 = s[w-j];
      @(posedge clk);
    end
    @(negedge clk);
    chk((w == 2) ? "w2_done_pulse" : "w16_done_pulse", (w == 2) ? done2 : done16, 1);
    @(posedge clk);
    @(negedge clk);
    chk((w == 2) ? "w2_busy_end" : "w16_busy_end", (w == 2) ? busy2 : busy16, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int seen;
    int t;
    rst = 1'b1; start = 1'b0; hold = 1'b0; si = 1'b0; din = '0;
    start2 = 1'b0; si2 = 1'b0; din2 = '0;
    start16 = 1'b0; si16 = 1'b0; din16 = '0;
    hold_off = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_so", so, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Basic transfer, then the same with a 3-cycle stall after edge 2.
    xfer6(6'b101100, 6'b110100, 0, 0, 1'b0);
    xfer6(6'b101100, 6'b110100, 2, 3, 1'b0);
    // START and HOLD poked while busy must be ignored.
    xfer6(6'b010011, 6'b001011, 0, 0, 1'b1);

    hold = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_hold_busy", busy, 0);
    end
    hold = 1'b0;

    // Reset mid-transfer with START also asserted.
    start = 1'b1;
    din   = 6'h2A;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_q", q, 0);
    chk("midrst_so", so, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen += int'(done);
    end
    chk("midrst_no_done", seen, 0);

    // Back-to-back with START held high.
    done_times.delete();
    start = 1'b1;
    din   = 6'b011010;
    si    = 1'b1;
    q6_exp.push_back(6'h3F);
    q6_exp.push_back(6'h3F);
    t = 0;
    while (done_times.size() < 2 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    si    = 1'b0;
    chk("b2b_done_count", done_times.size(), 2);
    if (done_times.size() >= 2) chk("b2b_period", done_times[1] - done_times[0], 8);
    repeat (4) @(negedge clk);

    xfer_w(2, 16'h0002, 16'h0001);
    xfer_w(2, 16'h0001, 16'h0003);
    xfer_w(16, 16'hA5C3, 16'h3C96);
    xfer_w(16, 16'h0F0F, 16'hF00F);
    repeat (3) @(negedge clk);

    chk("w6_drain", q6_exp.size(), 0);
    chk("w2_drain", q2_exp.size(), 0);
    chk("w16_drain", q16_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
